// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and decode-side resolution signals of the WISC branch predictor.
// The CPU pipeline is the master, the predictor is the slave.
interface branch_predictor_if;
  logic [15:0] PC_curr;
  logic        predicted_taken;
  logic [15:0] predicted_target;
  logic        update;
  logic [15:0] IF_ID_PC_curr;
  logic        IF_ID_predicted_taken;
  logic [15:0] IF_ID_predicted_target;
  logic        actual_taken;
  logic [15:0] actual_target;
  logic        mispredicted;
  logic        target_miscomputed;
  logic [15:0] branch_count;
  logic [15:0] mispredict_count;

  modport master (
    output PC_curr, update, IF_ID_PC_curr, IF_ID_predicted_taken,
           IF_ID_predicted_target, actual_taken, actual_target,
    input  predicted_taken, predicted_target, mispredicted,
           target_miscomputed, branch_count, mispredict_count
  );

  modport slave (
    input  PC_curr, update, IF_ID_PC_curr, IF_ID_predicted_taken,
           IF_ID_predicted_target, actual_taken, actual_target,
    output predicted_taken, predicted_target, mispredicted,
           target_miscomputed, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit saturating-counter predictor with a tagged BTB.
// Zero-latency lookup for fetch, resolution/update from decode, saturating statistics.
module branch_predictor #(
  parameter int NUM_ENTRIES = 16
) (
  input logic          clk,
  input logic          rst,
  branch_predictor_if.slave bp
);
  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int TAG_W = 15 - IDX_W;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [1:0]       cnt;
    logic [15:0]      target;
  } entry_t;

  localparam entry_t ENTRY_RESET = '{valid: 1'b0, tag: '0, cnt: 2'b01, target: 16'h0000};

  entry_t entries_q [NUM_ENTRIES];
  logic [15:0] branch_count_q;
  logic [15:0] mispredict_count_q;

  // Lookup side: word-aligned PC, bit 0 carries no information.
  logic [IDX_W-1:0] rd_idx;
  logic [TAG_W-1:0] rd_tag;
  entry_t           rd_entry;
  logic             rd_hit;

  assign rd_idx   = bp.PC_curr[IDX_W:1];
  assign rd_tag   = bp.PC_curr[15:IDX_W+1];
  assign rd_entry = entries_q[rd_idx];
  assign rd_hit   = rd_entry.valid && (rd_entry.tag == rd_tag);

  assign bp.predicted_taken  = rd_hit & rd_entry.cnt[1];
  assign bp.predicted_target = bp.predicted_taken ? rd_entry.target : 16'h0000;

  assign bp.mispredicted = bp.update & (bp.IF_ID_predicted_taken != bp.actual_taken);
  assign bp.target_miscomputed = bp.update & bp.IF_ID_predicted_taken & bp.actual_taken &
                                 (bp.IF_ID_predicted_target != bp.actual_target);

  assign bp.branch_count     = branch_count_q;
  assign bp.mispredict_count = mispredict_count_q;

  logic unused_pc_lsb;
  assign unused_pc_lsb = bp.PC_curr[0] ^ bp.IF_ID_PC_curr[0];

  // Resolution side: build the replacement entry for the resolving branch.
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] wr_tag;
  entry_t           wr_old;
  entry_t           wr_entry;
  logic             wr_hit;

  assign wr_idx = bp.IF_ID_PC_curr[IDX_W:1];
  assign wr_tag = bp.IF_ID_PC_curr[15:IDX_W+1];
  assign wr_old = entries_q[wr_idx];
  assign wr_hit = wr_old.valid && (wr_old.tag == wr_tag);

  always_comb begin
    // NOTE: wr_entry gets a full default before any branch so no path leaves it unassigned (no latch).
    wr_entry       = wr_old;
    wr_entry.valid = 1'b1;
    wr_entry.tag   = wr_tag;
    if (!wr_hit) begin
      wr_entry.cnt = bp.actual_taken ? 2'b10 : 2'b01;
    end else if (bp.actual_taken) begin
      if (wr_old.cnt != 2'b11) wr_entry.cnt = wr_old.cnt + 2'd1;
    end else begin
      if (wr_old.cnt != 2'b00) wr_entry.cnt = wr_old.cnt - 2'd1;
    end
    if (bp.actual_taken) wr_entry.target = bp.actual_target;
  end

  // NOTE: the table lives in flops, not RAM, because every entry must be cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) entries_q[i] <= ENTRY_RESET;
      branch_count_q     <= 16'h0000;
      mispredict_count_q <= 16'h0000;
    end else if (bp.update) begin
      // NOTE: non-blocking writes keep this cycle's lookup on the pre-update contents.
      entries_q[wr_idx] <= wr_entry;
      if (branch_count_q != 16'hFFFF) branch_count_q <= branch_count_q + 16'd1;
      if ((bp.mispredicted || bp.target_miscomputed) && (mispredict_count_q != 16'hFFFF))
        mispredict_count_q <= mispredict_count_q + 16'd1;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor (NUM_ENTRIES=16).
// Each vector is driven on the falling edge, checked before the next rising edge.
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  branch_predictor_if bp();
  branch_predictor #(.NUM_ENTRIES(16)) dut (.clk(clk), .rst(rst), .bp(bp));

  typedef struct {
    logic [15:0] pc;
    logic        upd;
    logic [15:0] br_pc;
    logic        br_pt;
    logic [15:0] br_ptgt;
    logic        at;
    logic [15:0] atgt;
    logic        e_pt;
    logic [15:0] e_tgt;
    logic        e_mp;
    logic        e_tm;
    logic [15:0] e_bc;
    logic [15:0] e_mc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic [15:0] pc, logic upd, logic [15:0] br_pc, logic br_pt,
                              logic [15:0] br_ptgt, logic at, logic [15:0] atgt,
                              logic e_pt, logic [15:0] e_tgt, logic e_mp, logic e_tm,
                              logic [15:0] e_bc, logic [15:0] e_mc);
    vec_t v;
    v.pc = pc; v.upd = upd; v.br_pc = br_pc; v.br_pt = br_pt; v.br_ptgt = br_ptgt;
    v.at = at; v.atgt = atgt; v.e_pt = e_pt; v.e_tgt = e_tgt; v.e_mp = e_mp;
    v.e_tm = e_tm; v.e_bc = e_bc; v.e_mc = e_mc;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bp.PC_curr                = v.pc;
    bp.update                 = v.upd;
    bp.IF_ID_PC_curr          = v.br_pc;
    bp.IF_ID_predicted_taken  = v.br_pt;
    bp.IF_ID_predicted_target = v.br_ptgt;
    bp.actual_taken           = v.at;
    bp.actual_target          = v.atgt;
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    check({tag, " pred_taken"},  {31'd0, bp.predicted_taken},    {31'd0, v.e_pt});
    check({tag, " pred_target"}, {16'd0, bp.predicted_target},   {16'd0, v.e_tgt});
    check({tag, " mispred"},     {31'd0, bp.mispredicted},       {31'd0, v.e_mp});
    check({tag, " tgt_miscomp"}, {31'd0, bp.target_miscomputed}, {31'd0, v.e_tm});
    check({tag, " branch_cnt"},  {16'd0, bp.branch_count},       {16'd0, v.e_bc});
    check({tag, " mispred_cnt"}, {16'd0, bp.mispredict_count},   {16'd0, v.e_mc});
  endtask

  // Expected values are pre-edge: predictions and counts reflect state before this vector commits.
  initial begin
    // pc    upd br_pc   br_pt br_ptgt at atgt      e_pt e_tgt  mp tm  bc  mc
    vecs.push_back(mk(16'h0010, 1, 16'h0010, 0, 16'h0000, 1, 16'h0040, 0, 16'h0000, 1, 0, 0, 0));  // allocate taken
    vecs.push_back(mk(16'h0010, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h0040, 0, 0, 1, 1));
    vecs.push_back(mk(16'h0010, 1, 16'h0010, 1, 16'h0040, 1, 16'h0040, 1, 16'h0040, 0, 0, 1, 1));  // cnt 10->11
    vecs.push_back(mk(16'h0010, 1, 16'h0010, 1, 16'h0040, 1, 16'h0040, 1, 16'h0040, 0, 0, 2, 1));  // stays 11
    vecs.push_back(mk(16'h0010, 1, 16'h0010, 1, 16'h0040, 0, 16'h0012, 1, 16'h0040, 1, 0, 3, 1));  // 11->10
    vecs.push_back(mk(16'h0010, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h0040, 0, 0, 4, 2));
    vecs.push_back(mk(16'h0010, 1, 16'h0010, 1, 16'h0040, 0, 16'h0012, 1, 16'h0040, 1, 0, 4, 2));  // 10->01
    vecs.push_back(mk(16'h0010, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 5, 3));
    vecs.push_back(mk(16'h0010, 1, 16'h0010, 0, 16'h0000, 1, 16'h0040, 0, 16'h0000, 1, 0, 5, 3));  // 01->10
    vecs.push_back(mk(16'h0010, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h0040, 0, 0, 6, 4));
    vecs.push_back(mk(16'h0030, 1, 16'h0030, 0, 16'h0000, 0, 16'h0032, 0, 16'h0000, 0, 0, 6, 4));  // alias alloc NT
    vecs.push_back(mk(16'h0010, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 7, 4));  // evicted
    vecs.push_back(mk(16'h0030, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 7, 4));  // cnt 01
    vecs.push_back(mk(16'h0030, 1, 16'h0010, 0, 16'h0000, 1, 16'h0040, 0, 16'h0000, 1, 0, 7, 4));  // realloc 0x10
    vecs.push_back(mk(16'h0010, 1, 16'h0010, 1, 16'h0040, 1, 16'h0040, 1, 16'h0040, 0, 0, 8, 5));  // 10->11
    vecs.push_back(mk(16'h0010, 1, 16'h0010, 1, 16'h0040, 1, 16'h0080, 1, 16'h0040, 0, 1, 9, 5));  // target change, old seen
    vecs.push_back(mk(16'h0010, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h0080, 0, 0, 10, 6));
    vecs.push_back(mk(16'h0011, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h0080, 0, 0, 10, 6)); // PC[0] ignored
    vecs.push_back(mk(16'h0012, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 10, 6));

    drive(mk(16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0));
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Post-reset sweep: every PC misses.
    for (int p = 0; p < 16; p++) begin
      vec_t v;
      v = mk(16'(p * 2), 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0);
      drive(v);
      #1;
      check_vec($sformatf("sweep pc=%04h", p * 2), v);
      @(negedge clk);
    end

    foreach (vecs[i]) begin
      drive(vecs[i]);
      #1;
      check_vec($sformatf("vec%0d", i), vecs[i]);
      @(negedge clk);
    end

    // Reset wins over a simultaneous update.
    drive(mk(16'h0020, 1, 16'h0020, 0, 16'h0000, 1, 16'h0100, 0, 16'h0000, 0, 0, 0, 0));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(mk(16'h0020, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0));
    #1;
    check("rst+upd pred_taken 0x20", {31'd0, bp.predicted_taken}, 32'd0);
    check("rst+upd branch_cnt",      {16'd0, bp.branch_count}, 32'd0);
    check("rst+upd mispred_cnt",     {16'd0, bp.mispredict_count}, 32'd0);
    bp.PC_curr = 16'h0010;
    #1;
    check("rst clears 0x10", {31'd0, bp.predicted_taken}, 32'd0);
    @(negedge clk);

    // Saturation: 65537 mispredicting updates.
    drive(mk(16'h0000, 1, 16'h0040, 0, 16'h0000, 1, 16'h0044, 0, 16'h0000, 0, 0, 0, 0));
    repeat (65534) @(posedge clk);
    @(negedge clk);
    check("sat pre mispred_cnt", {16'd0, bp.mispredict_count}, 32'h0000FFFE);
    check("sat pre branch_cnt",  {16'd0, bp.branch_count},     32'h0000FFFE);
    repeat (3) @(posedge clk);
    @(negedge clk);
    bp.update = 1'b0;
    #1;
    check("sat mispred_cnt", {16'd0, bp.mispredict_count}, 32'h0000FFFF);
    check("sat branch_cnt",  {16'd0, bp.branch_count},     32'h0000FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor for the 16-bit five-stage WISC CPU.
- Sits beside the fetch stage. It supplies a taken/target prediction for the fetch PC, then accepts branch resolution (B/BR) from the decode stage.
- It raises the misprediction indication that drives the IF flush, and keeps branch/mispredict statistics for the trace bench.
- Storage is a direct-mapped table of 2-bit saturating counters with a tagged branch target buffer (BTB).

Parameters:
- NUM_ENTRIES, 16, number of table entries. Must be a power of 2, from 4 to 64.
- IDX_W, $clog2(NUM_ENTRIES), index width. Derived; do not override.
- TAG_W, 15-IDX_W, tag width. Derived from PC[15:IDX_W+1].

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- PC_curr  in  16  fetch-stage PC. Byte address, word aligned, so PC[0] is ignored.
- predicted_taken  out  1  fetch prediction: taken.
- predicted_target  out  16  fetch prediction: target address.
- update  in  1  a decode-stage B/BR is resolving this cycle; already qualified with ~IF_ID_stall.
- IF_ID_PC_curr  in  16  PC of the resolving branch.
- IF_ID_predicted_taken  in  1  prediction that was carried down the pipe with that branch.
- IF_ID_predicted_target  in  16  predicted target that was carried with it.
- actual_taken  in  1  resolved direction.
- actual_target  in  16  resolved target.
- mispredicted  out  1  direction was wrong.
- target_miscomputed  out  1  direction was right and taken, but the target was wrong.
- branch_count  out  16  number of resolved branches.
- mispredict_count  out  16  number of resolved branches with a wrong direction or wrong target.

Behaviour:
- Entry contents: valid (1), tag (TAG_W), cnt (2), target (16).
  - Index is PC[IDX_W:1].
  - Tag is PC[15:IDX_W+1].
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Reset, when rst=1 at a clock edge:
  - All entries become valid=0, cnt=01, tag=0, target=0.
  - Both statistics counters become 0.
  - rst has priority over update.
  - Outputs after reset: predicted_taken=0, predicted_target=0000. mispredicted and target_miscomputed are 0 while update=0.
- Lookup (combinational, zero latency from PC_curr):
  - hit = valid & (tag == PC_curr tag).
  - predicted_taken = hit & cnt[1].
  - predicted_target = predicted_taken ? target : 16'h0000.
- Resolution outputs (combinational):
  - mispredicted = update & (IF_ID_predicted_taken != actual_taken).
  - target_miscomputed = update & IF_ID_predicted_taken & actual_taken & (IF_ID_predicted_target != actual_target).
  - Both are 0 when update=0.
- Table update at the clock edge when update=1 and rst=0, using the entry at IF_ID_PC_curr:
  - Tag miss or invalid entry: allocate it.
    - valid=1, tag written.
    - cnt = actual_taken ? 10 : 01.
    - target = actual_target if actual_taken, otherwise the old target is kept.
  - Tag hit:
    - cnt saturates: +1 if taken (stops at 11), -1 if not taken (stops at 00).
    - target is overwritten with actual_target only when actual_taken=1.
- Simultaneous lookup and update of the same index in one cycle: the lookup returns the pre-update contents. There is no write-through bypass; the new value is visible on the next cycle.
- Aliasing: a tag mismatch is a miss even when the index is valid. Allocation overwrites the aliasing entry.
- Statistics counters:
  - branch_count increments on every cycle with update=1.
  - mispredict_count increments when mispredicted | target_miscomputed.
  - Both saturate at FFFF and do not wrap.
- The block has no stall input. The caller gates update, and a stalled fetch simply re-presents the same PC_curr.

Test Plan:
- Reset, then sweep PC_curr 0000..001E → predicted_taken=0 and predicted_target=0000 at every PC. Counts stay 0.
- Branch at PC 0x0010: update with taken to target 0x0040 and IF_ID_predicted_taken=0 → mispredicted=1, counts 1/1. Next cycle PC_curr=0x0010 → predicted_taken=1, predicted_target=0x0040.
- Same branch resolved taken twice, then not-taken once → cnt goes 10→11→11→10, and prediction stays taken. A second not-taken → cnt=01, so PC 0x0010 now predicts not taken.
- Aliasing with NUM_ENTRIES=16: PC 0x0010 is allocated taken, then PC 0x0030 (same index, different tag) is resolved not-taken. Lookup of 0x0010 → miss, predicted_taken=0. Lookup of 0x0030 → predicted_taken=0 (cnt=01).
- Target change: entry 0x0010 holds cnt=11, target 0x0040. Resolve with predicted_target 0x0040 against actual 0x0080 → target_miscomputed=1, mispredicted=0. The new target 0x0080 appears on the next lookup. Same-cycle lookup of 0x0010 still returns 0x0040.
- Assert rst in the same cycle as update=1 → no allocation and counts = 0. Then force 65537 mispredicting updates → mispredict_count holds at FFFF.
